rtc_alarm_timer: RTL and testbench

Parametrised real-time clock with configurable sub-second resolution, coherent snapshot read-out, and `NUM_ALARMS` independent seconds-match alarm channels with sticky interrupt flags. It is the successor to the fixed 20-bit/32-bit seconds counter. It sits behind the peripheral register interface, consumes the shared 1 µs tick, and drives the interrupt line to the CPU.

---
 rtl/rtc_pkg.sv | 26 ++
 rtl/rtc_alarm_channel.sv | 47 ++++
 rtl/rtc_alarm_timer.sv | 114 +++++++++++
 tb/tb_rtc_alarm_timer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and elaboration helpers for the real-time clock.
// Contents:
//   RTC_TICKS_PER_SEC / RTC_SUB_W / RTC_SEC_W - default geometry (1 us tick).
//   RTC_MAX_ALARMS                            - largest legal alarm count.
//   rtc_sub_last()                            - terminal sub-second count.
//   rtc_params_ok()                           - geometry legality check.
package rtc_pkg;

  localparam int RTC_TICKS_PER_SEC = 1_000_000;
  localparam int RTC_SUB_W         = 20;
  localparam int RTC_SEC_W         = 32;
  localparam int RTC_MAX_ALARMS    = 8;

  // Last sub-second value before a seconds rollover.
  function automatic int rtc_sub_last(input int ticks_per_sec);
    return ticks_per_sec - 1;
  endfunction

  // The sub-second counter must be able to hold 0..ticks_per_sec-1.
  // 64-bit arithmetic keeps the shift safe for sub_w up to 32.
  function automatic bit rtc_params_ok(input int ticks_per_sec, input int sub_w);
    return (ticks_per_sec >= 2) &&
           (longint'(ticks_per_sec) <= (longint'(1) << sub_w));
  endfunction

endpackage

// File: rtl/rtc_alarm_channel.sv
// One seconds-match alarm channel: compare register, match logic and a
// sticky interrupt flag.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   rollover      - counting rollover happens on this edge
//   next_seconds  - seconds value that the rollover is about to load
//   ena           - channel enable level
//   wr_en/wr_data - compare register write
//   clr           - write-1-to-clear for the flag
//   irq_flag      - sticky match flag
module rtc_alarm_channel
  import rtc_pkg::*;
#(
  parameter int SEC_W = RTC_SEC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rollover,
  input  logic [SEC_W-1:0] next_seconds,
  input  logic             ena,
  input  logic             wr_en,
  input  logic [SEC_W-1:0] wr_data,
  input  logic             clr,
  output logic             irq_flag
);

  logic [SEC_W-1:0] cmp_q;
  logic             match_set;

  // The match reads cmp_q before this edge's write lands, so a compare
  // write coinciding with a rollover is judged against the old value.
  assign match_set = rollover && ena && (next_seconds == cmp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the compare register resets to all-ones, not zero, so a
      // freshly reset channel cannot fire on the first rollover to 0.
      cmp_q    <= '1;
      irq_flag <= 1'b0;
    end else begin
      if (wr_en) cmp_q <= wr_data;
      // Set has priority over a simultaneous clear.
      irq_flag <= match_set | (irq_flag & ~clr);
    end
  end

endmodule

// File: rtl/rtc_alarm_timer.sv
// Parametrised real-time clock: sub-second and seconds counters driven by
// a shared tick, coherent snapshot capture, and NUM_ALARMS seconds-match
// alarm channels with sticky flags.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   tick, run                   - tick pulse, count enable level
//   sec_wr_en, sec_wr_data      - seconds load (clears sub-second count)
//   alarm_wr_en, alarm_wr_data  - per-channel compare write, shared data
//   alarm_ena, irq_clr          - per-channel enable, flag clear
//   snap                        - capture the current seconds/subsec pair
//   seconds_out, subsec_out     - live counters
//   snap_sec, snap_sub          - captured pair
//   sec_pulse                   - one cycle after each counting rollover
//   irq_flag, irq               - sticky flags and their OR
module rtc_alarm_timer
  import rtc_pkg::*;
#(
  parameter int TICKS_PER_SEC = RTC_TICKS_PER_SEC,
  parameter int SUB_W         = RTC_SUB_W,
  parameter int SEC_W         = RTC_SEC_W,
  parameter int NUM_ALARMS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  sec_wr_en,
  input  logic [SEC_W-1:0]      sec_wr_data,
  input  logic [NUM_ALARMS-1:0] alarm_wr_en,
  input  logic [SEC_W-1:0]      alarm_wr_data,
  input  logic [NUM_ALARMS-1:0] alarm_ena,
  input  logic [NUM_ALARMS-1:0] irq_clr,
  input  logic                  snap,
  output logic [SEC_W-1:0]      seconds_out,
  output logic [SUB_W-1:0]      subsec_out,
  output logic [SEC_W-1:0]      snap_sec,
  output logic [SUB_W-1:0]      snap_sub,
  output logic                  sec_pulse,
  output logic [NUM_ALARMS-1:0] irq_flag,
  output logic                  irq
);

  if (!rtc_params_ok(TICKS_PER_SEC, SUB_W)) begin : g_bad_ticks
    $fatal(1, "rtc_alarm_timer: TICKS_PER_SEC must be in 2..2**SUB_W");
  end
  if (NUM_ALARMS < 1 || NUM_ALARMS > RTC_MAX_ALARMS) begin : g_bad_alarms
    $fatal(1, "rtc_alarm_timer: NUM_ALARMS must be in 1..8");
  end

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(rtc_sub_last(TICKS_PER_SEC));

  logic [SEC_W-1:0] seconds_q;
  logic [SUB_W-1:0] subsec_q;
  logic [SEC_W-1:0] seconds_inc;
  logic             count_en;
  logic             rollover;

  // A seconds write owns the cycle: the tick is dropped, so neither an
  // increment nor a rollover (and hence no alarm match) can occur.
  assign count_en    = tick && run && !sec_wr_en;
  assign rollover    = count_en && (subsec_q == SUB_LAST);
  assign seconds_inc = seconds_q + SEC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seconds_q <= '0;
      subsec_q  <= '0;
      snap_sec  <= '0;
      snap_sub  <= '0;
      sec_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every read below see the
      // pre-edge values, which is what keeps the snapshot coherent.
      if (sec_wr_en) begin
        seconds_q <= sec_wr_data;
        subsec_q  <= '0;
      end else if (count_en) begin
        if (rollover) begin
          seconds_q <= seconds_inc;
          subsec_q  <= '0;
        end else begin
          subsec_q <= subsec_q + SUB_W'(1);
        end
      end
      if (snap) begin
        snap_sec <= seconds_q;
        snap_sub <= subsec_q;
      end
      sec_pulse <= rollover;
    end
  end

  assign seconds_out = seconds_q;
  assign subsec_out  = subsec_q;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    rtc_alarm_channel #(
      .SEC_W (SEC_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .rollover     (rollover),
      .next_seconds (seconds_inc),
      .ena          (alarm_ena[i]),
      .wr_en        (alarm_wr_en[i]),
      .wr_data      (alarm_wr_data),
      .clr          (irq_clr[i]),
      .irq_flag     (irq_flag[i])
    );
  end

  assign irq = |irq_flag;

endmodule

// File: tb/tb_rtc_alarm_timer.sv
// Self-checking bench for rtc_alarm_timer. A small-geometry instance
// (10 ticks per second) exercises rollover, wrap, alarms and snapshot;
// a default-geometry instance shares the counting inputs and checks the
// 1_000_000-tick sub-second counter.
module tb_rtc_alarm_timer;

  localparam int TPS  = 10;
  localparam int SUBW = 4;
  localparam int DTPS = 1_000_000;
  localparam int DSUBW = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, run, sec_wr_en, snap;
  logic [31:0] sec_wr_data, alarm_wr_data;
  logic [1:0]  alarm_wr_en, alarm_ena, irq_clr;

  logic [31:0]      seconds_out, snap_sec;
  logic [SUBW-1:0]  subsec_out, snap_sub;
  logic             sec_pulse, irq;
  logic [1:0]       irq_flag;

  logic [31:0]      d_seconds, d_snap_sec;
  logic [DSUBW-1:0] d_subsec, d_snap_sub;
  logic             d_sec_pulse, d_irq;
  logic [1:0]       d_irq_flag;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [31:0]      m_sec, m_snap_sec;
  logic [SUBW-1:0]  m_sub, m_snap_sub;
  logic             m_pulse;
  logic [1:0]       m_flag;
  logic [31:0]      m_cmp [2];
  logic [31:0]      md_sec;
  logic [DSUBW-1:0] md_sub;

  always #5 clk = ~clk;

  rtc_alarm_timer #(
    .TICKS_PER_SEC (TPS), .SUB_W (SUBW), .SEC_W (32), .NUM_ALARMS (2)
  ) u_dut (
    .clk (clk), .rst (rst), .tick (tick), .run (run),
    .sec_wr_en (sec_wr_en), .sec_wr_data (sec_wr_data),
    .alarm_wr_en (alarm_wr_en), .alarm_wr_data (alarm_wr_data),
    .alarm_ena (alarm_ena), .irq_clr (irq_clr), .snap (snap),
    .seconds_out (seconds_out), .subsec_out (subsec_out),
    .snap_sec (snap_sec), .snap_sub (snap_sub),
    .sec_pulse (sec_pulse), .irq_flag (irq_flag), .irq (irq)
  );

  rtc_alarm_timer u_dut_def (
    .clk (clk), .rst (rst), .tick (tick), .run (run),
    .sec_wr_en (sec_wr_en), .sec_wr_data (sec_wr_data),
    .alarm_wr_en (2'b00), .alarm_wr_data (32'h0),
    .alarm_ena (2'b00), .irq_clr (2'b00), .snap (1'b0),
    .seconds_out (d_seconds), .subsec_out (d_subsec),
    .snap_sec (d_snap_sec), .snap_sub (d_snap_sub),
    .sec_pulse (d_sec_pulse), .irq_flag (d_irq_flag), .irq (d_irq)
  );

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_sec = '0; m_sub = '0; m_snap_sec = '0; m_snap_sub = '0;
    m_pulse = 1'b0; m_flag = '0; m_cmp[0] = '1; m_cmp[1] = '1;
    md_sec = '0; md_sub = '0;
  endtask

  // Apply the clock-edge rules to the model using the inputs in force.
  task automatic model_edge();
    logic roll;
    roll = 1'b0;
    if (snap) begin
      m_snap_sec = m_sec;
      m_snap_sub = m_sub;
    end
    if (sec_wr_en) begin
      m_sec = sec_wr_data; m_sub = '0;
      md_sec = sec_wr_data; md_sub = '0;
    end else if (tick && run) begin
      if (int'(m_sub) == TPS - 1) begin
        m_sub = '0; m_sec = m_sec + 1; roll = 1'b1;
      end else begin
        m_sub = m_sub + 1;
      end
      if (int'(md_sub) == DTPS - 1) begin
        md_sub = '0; md_sec = md_sec + 1;
      end else begin
        md_sub = md_sub + 1;
      end
    end
    m_pulse = roll;
    for (int i = 0; i < 2; i++) begin
      if (roll && alarm_ena[i] && m_sec == m_cmp[i]) m_flag[i] = 1'b1;
      else if (irq_clr[i]) m_flag[i] = 1'b0;
      if (alarm_wr_en[i]) m_cmp[i] = alarm_wr_data;
    end
  endtask

  // One clock: model follows the edge, then return at the falling edge
  // where outputs are sampled and the next inputs are driven.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    tick = 0; run = 1; sec_wr_en = 0; sec_wr_data = '0; snap = 0;
    alarm_wr_en = '0; alarm_wr_data = '0; irq_clr = '0;
  endtask

  task automatic write_sec(input logic [31:0] v);
    sec_wr_en = 1; sec_wr_data = v;
    step();
    sec_wr_en = 0;
  endtask

  task automatic ticks(input int n);
    tick = 1;
    repeat (n) step();
    tick = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    alarm_ena = '0;
    write_sec(32'd33);
    ticks(5);
    snap = 1; step(); snap = 0;
    // Assert reset between edges: outputs must clear without a clock.
    rst = 1;
    #1;
    model_reset();
    if (seconds_out !== 32'd0) begin n_fail++; $display("FAIL reset_sec: got %0d expected 0", seconds_out); end
    n_assert++;
    if (subsec_out !== 4'd0) begin n_fail++; $display("FAIL reset_sub: got %0d expected 0", subsec_out); end
    n_assert++;
    if (snap_sec !== 32'd0 || snap_sub !== 4'd0) begin n_fail++; $display("FAIL reset_snap: got %0d/%0d expected 0/0", snap_sec, snap_sub); end
    n_assert++;
    if (irq !== 1'b0 || irq_flag !== 2'b00 || sec_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got irq=%b flag=%b pulse=%b expected 0", irq, irq_flag, sec_pulse); end
    n_assert++;
    if (d_seconds !== 32'd0 || d_subsec !== 20'd0) begin n_fail++; $display("FAIL reset_default: got %0d/%0d expected 0/0", d_seconds, d_subsec); end
    n_assert++;
    @(negedge clk);
    rst = 0;
  endtask

  // Compare registers come out of reset all-ones: rolling onto
  // 0xFFFFFFFF with both channels enabled must flag both.
  task automatic test_wrap();
    alarm_ena = 2'b11;
    write_sec(32'hFFFF_FFFE);
    ticks(TPS);
    if (seconds_out !== 32'hFFFF_FFFF || sec_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_to_max: got %h pulse=%b expected ffffffff pulse=1", seconds_out, sec_pulse); end
    n_assert++;
    if (irq_flag !== 2'b11 || irq !== 1'b1) begin n_fail++; $display("FAIL reset_cmp_ones: got flag=%b irq=%b expected 11/1", irq_flag, irq); end
    n_assert++;
    irq_clr = 2'b11; step(); irq_clr = 2'b00;
    if (irq_flag !== 2'b00 || irq !== 1'b0) begin n_fail++; $display("FAIL clear_both: got flag=%b irq=%b expected 00/0", irq_flag, irq); end
    n_assert++;
    alarm_ena = 2'b00;
    ticks(TPS - 1);
    if (subsec_out !== 4'd9) begin n_fail++; $display("FAIL wrap_sub9: got %0d expected 9", subsec_out); end
    n_assert++;
    ticks(1);
    if (seconds_out !== 32'd0 || subsec_out !== 4'd0 || sec_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_to_zero: got %0d/%0d pulse=%b expected 0/0 pulse=1", seconds_out, subsec_out, sec_pulse); end
    n_assert++;
  endtask

  task automatic test_rollover();
    write_sec(32'd0);
    ticks(8);
    ticks(1);
    if (seconds_out !== 32'd0 || subsec_out !== 4'd9 || sec_pulse !== 1'b0) begin n_fail++; $display("FAIL pre_roll: got %0d/%0d pulse=%b expected 0/9 pulse=0", seconds_out, subsec_out, sec_pulse); end
    n_assert++;
    ticks(1);
    if (seconds_out !== 32'd1 || subsec_out !== 4'd0 || sec_pulse !== 1'b1) begin n_fail++; $display("FAIL roll: got %0d/%0d pulse=%b expected 1/0 pulse=1", seconds_out, subsec_out, sec_pulse); end
    n_assert++;
    step();
    if (sec_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b expected 0", sec_pulse); end
    n_assert++;
  endtask

  task automatic test_write_priority();
    write_sec(32'd40);
    ticks(TPS - 1);
    sec_wr_en = 1; sec_wr_data = 32'd500; tick = 1;
    step();
    sec_wr_en = 0; tick = 0;
    if (seconds_out !== 32'd500 || subsec_out !== 4'd0 || sec_pulse !== 1'b0) begin n_fail++; $display("FAIL wr_priority: got %0d/%0d pulse=%b expected 500/0 pulse=0", seconds_out, subsec_out, sec_pulse); end
    n_assert++;
    if (d_seconds !== 32'd500 || d_subsec !== 20'd0) begin n_fail++; $display("FAIL wr_priority_default: got %0d/%0d expected 500/0", d_seconds, d_subsec); end
    n_assert++;
  endtask

  task automatic test_alarm();
    alarm_wr_en = 2'b01; alarm_wr_data = 32'd101; step(); alarm_wr_en = 2'b00;
    alarm_ena = 2'b01;
    write_sec(32'd100);
    ticks(TPS);
    if (irq_flag !== 2'b01 || irq !== 1'b1 || sec_pulse !== 1'b1) begin n_fail++; $display("FAIL alarm_match: got flag=%b irq=%b pulse=%b expected 01/1/1", irq_flag, irq, sec_pulse); end
    n_assert++;
    // Clear coinciding with a fresh match: set wins.
    write_sec(32'd100);
    ticks(TPS - 1);
    irq_clr = 2'b01; tick = 1; step(); irq_clr = 2'b00; tick = 0;
    if (irq_flag !== 2'b01) begin n_fail++; $display("FAIL set_beats_clr: got %b expected 01", irq_flag); end
    n_assert++;
    irq_clr = 2'b01; step(); irq_clr = 2'b00;
    if (irq_flag !== 2'b00 || irq !== 1'b0) begin n_fail++; $display("FAIL clr_only: got flag=%b irq=%b expected 00/0", irq_flag, irq); end
    n_assert++;
    write_sec(32'd101);
    step();
    if (irq_flag !== 2'b00) begin n_fail++; $display("FAIL write_no_match: got %b expected 00", irq_flag); end
    n_assert++;
    // Compare rewritten on the matching rollover: old value still hits.
    write_sec(32'd100);
    ticks(TPS - 1);
    alarm_wr_en = 2'b01; alarm_wr_data = 32'd555; tick = 1;
    step();
    alarm_wr_en = 2'b00; tick = 0;
    if (irq_flag !== 2'b01) begin n_fail++; $display("FAIL old_cmp_used: got %b expected 01", irq_flag); end
    n_assert++;
    alarm_ena = 2'b00; step();
    if (irq_flag !== 2'b01) begin n_fail++; $display("FAIL ena_keeps_flag: got %b expected 01", irq_flag); end
    n_assert++;
    irq_clr = 2'b01; step(); irq_clr = 2'b00;
    // Channel 1 alone, and channel 0 disabled while its compare matches.
    alarm_wr_en = 2'b10; alarm_wr_data = 32'd555; step(); alarm_wr_en = 2'b00;
    alarm_ena = 2'b10;
    write_sec(32'd554);
    ticks(TPS);
    if (irq_flag !== 2'b10 || irq !== 1'b1) begin n_fail++; $display("FAIL chan1_only: got flag=%b irq=%b expected 10/1", irq_flag, irq); end
    n_assert++;
    irq_clr = 2'b11; alarm_ena = 2'b00; step(); irq_clr = 2'b00;
  endtask

  task automatic test_snapshot();
    write_sec(32'd7);
    ticks(TPS - 1);
    snap = 1; tick = 1; step(); snap = 0; tick = 0;
    if (snap_sec !== 32'd7 || snap_sub !== 4'd9) begin n_fail++; $display("FAIL snap_pair: got %0d/%0d expected 7/9", snap_sec, snap_sub); end
    n_assert++;
    if (seconds_out !== 32'd8 || subsec_out !== 4'd0) begin n_fail++; $display("FAIL snap_live: got %0d/%0d expected 8/0", seconds_out, subsec_out); end
    n_assert++;
    ticks(3);
    if (snap_sec !== 32'd7 || snap_sub !== 4'd9) begin n_fail++; $display("FAIL snap_hold: got %0d/%0d expected 7/9", snap_sec, snap_sub); end
    n_assert++;
  endtask

  task automatic test_run_gating();
    write_sec(32'd0);
    ticks(4);
    run = 0;
    ticks(50);
    run = 1;
    if (seconds_out !== 32'd0 || subsec_out !== 4'd4) begin n_fail++; $display("FAIL run_gate: got %0d/%0d expected 0/4", seconds_out, subsec_out); end
    n_assert++;
    if (d_subsec !== 20'd4) begin n_fail++; $display("FAIL run_gate_default: got %0d expected 4", d_subsec); end
    n_assert++;
    write_sec(32'd0);
    ticks(TPS);
    if (seconds_out !== 32'd1 || subsec_out !== 4'd0) begin n_fail++; $display("FAIL small_tps: got %0d/%0d expected 1/0", seconds_out, subsec_out); end
    n_assert++;
    if (d_seconds !== 32'd0 || d_subsec !== 20'd10) begin n_fail++; $display("FAIL default_tps: got %0d/%0d expected 0/10", d_seconds, d_subsec); end
    n_assert++;
  endtask

  task automatic test_random();
    logic [31:0] base;
    for (int c = 0; c < 3000; c++) begin
      tick      = ($urandom_range(0, 9) < 7);
      run       = ($urandom_range(0, 9) != 0);
      snap      = ($urandom_range(0, 9) == 0);
      sec_wr_en = ($urandom_range(0, 99) < 2);
      base      = m_sec;
      sec_wr_data   = base + 32'($urandom_range(0, 2));
      alarm_wr_en   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      alarm_wr_data = base + 32'($urandom_range(0, 3));
      irq_clr       = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 49) == 0) alarm_ena = 2'($urandom_range(0, 3));
      step();
      if (seconds_out !== m_sec || subsec_out !== m_sub) begin n_fail++; $display("FAIL rnd_live c=%0d: got %0d/%0d expected %0d/%0d", c, seconds_out, subsec_out, m_sec, m_sub); end
      n_assert++;
      if (sec_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse c=%0d: got %b expected %b", c, sec_pulse, m_pulse); end
      n_assert++;
      if (irq_flag !== m_flag || irq !== (|m_flag)) begin n_fail++; $display("FAIL rnd_irq c=%0d: got flag=%b irq=%b expected %b", c, irq_flag, irq, m_flag); end
      n_assert++;
      if (snap_sec !== m_snap_sec || snap_sub !== m_snap_sub) begin n_fail++; $display("FAIL rnd_snap c=%0d: got %0d/%0d expected %0d/%0d", c, snap_sec, snap_sub, m_snap_sec, m_snap_sub); end
      n_assert++;
      if (d_seconds !== md_sec || d_subsec !== md_sub) begin n_fail++; $display("FAIL rnd_default c=%0d: got %0d/%0d expected %0d/%0d", c, d_seconds, d_subsec, md_sec, md_sub); end
      n_assert++;
    end
    idle_inputs();
    alarm_ena = '0;
    step();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    alarm_ena = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_wrap();
    test_rollover();
    test_write_priority();
    test_alarm();
    test_snapshot();
    test_run_gating();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
